ifid_hazard_ctrl: RTL

Pipeline hazard controller sequencing the IF/ID pipeline register and its neighbours. Each cycle it turns hazard requests into stall, flush and redirect controls: the ID-stage load-use detector, EX-stage branch mispredict, I-cache busy and D-cache busy. It drives the IF/ID register's STALL and FLUSH inputs, the PC stall, the ID/EX bubble and the fetch redirect. It also holds a mispredict redirect pending across multi-cycle memory stalls and keeps stall/flush performance counters.

---
 rtl/ifid_hazard_ctrl_pkg.sv | 14 +
 rtl/ifid_hazard_ctrl_perf_counter.sv | 19 +
 rtl/ifid_hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared types for the IF/ID hazard controller: FSM states and stall-cause codes.
package ifid_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_DCACHE  = 2'd1;
  localparam logic [1:0] CAUSE_LOADUSE = 2'd2;
  localparam logic [1:0] CAUSE_ICACHE  = 2'd3;

endpackage

// File: rtl/ifid_hazard_ctrl_perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W; clears on synchronous active-low reset.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// Turns load-use, mispredict and cache-busy requests into IF/ID, ID/EX and PC controls,
// deferring a mispredict redirect while the D-cache holds the whole pipe.
module ifid_hazard_ctrl
  import ifid_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LoadUse_hazard,
  input  logic             Mispredict,
  input  logic [31:0]      Mispredict_target,
  input  logic             Icache_busy,
  input  logic             Dcache_busy,
  output logic             STALL_PC,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEX,
  output logic             FLUSH_IDEX,
  output logic             Redirect_valid,
  output logic [31:0]      Redirect_PC,
  output logic [1:0]       Stall_cause,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count,
  output logic             Timeout_err,
  output state_t           Fsm_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t              state, state_next;
  logic                pend_valid, pend_valid_next;
  logic [31:0]         pend_pc, pend_pc_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic                timeout_next;

  assign Fsm_state = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= RUN;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
      wait_cnt    <= '0;
      Timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      pend_valid  <= pend_valid_next;
      pend_pc     <= pend_pc_next;
      wait_cnt    <= wait_cnt_next;
      Timeout_err <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state;
    pend_valid_next = pend_valid;
    pend_pc_next    = pend_pc;
    wait_cnt_next   = wait_cnt;
    timeout_next    = Timeout_err;
    case (state)
      RUN: begin
        if (Dcache_busy) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
          if (Mispredict) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = Mispredict_target;
          end
        end
      end
      MEM_WAIT: begin
        if (Dcache_busy) begin
          if (wait_cnt < WAIT_MAX) wait_cnt_next = wait_cnt + WAIT_W'(1);
          if (wait_cnt >= WAIT_MAX) timeout_next = 1'b1;
          // EX is frozen, so a mispredict repeated while one is pending is the same branch.
          if (Mispredict && !pend_valid) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = Mispredict_target;
          end
        end else begin
          state_next      = RUN;
          pend_valid_next = 1'b0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    STALL_PC       = 1'b0;
    STALL_IFID     = 1'b0;
    FLUSH_IFID     = 1'b0;
    STALL_IDEX     = 1'b0;
    FLUSH_IDEX     = 1'b0;
    Redirect_valid = 1'b0;
    Redirect_PC    = '0;
    Stall_cause    = CAUSE_NONE;
    if (!RESET) begin
      FLUSH_IFID = 1'b1;
      FLUSH_IDEX = 1'b1;
    end else if (state == MEM_WAIT && Dcache_busy) begin
      STALL_PC    = 1'b1;
      STALL_IFID  = 1'b1;
      STALL_IDEX  = 1'b1;
      Stall_cause = CAUSE_DCACHE;
    end else if (state == MEM_WAIT && pend_valid) begin
      FLUSH_IFID     = 1'b1;
      FLUSH_IDEX     = 1'b1;
      Redirect_valid = 1'b1;
      Redirect_PC    = pend_pc;
    end else if (Mispredict && !Dcache_busy) begin
      FLUSH_IFID     = 1'b1;
      FLUSH_IDEX     = 1'b1;
      Redirect_valid = 1'b1;
      Redirect_PC    = Mispredict_target;
    end else if (Dcache_busy) begin
      STALL_PC    = 1'b1;
      STALL_IFID  = 1'b1;
      STALL_IDEX  = 1'b1;
      Stall_cause = CAUSE_DCACHE;
    end else if (LoadUse_hazard) begin
      // Load-use wins over I-cache: IF/ID holds its instruction rather than being bubbled.
      STALL_PC    = 1'b1;
      STALL_IFID  = 1'b1;
      FLUSH_IDEX  = 1'b1;
      Stall_cause = CAUSE_LOADUSE;
    end else if (Icache_busy) begin
      STALL_PC    = 1'b1;
      FLUSH_IFID  = 1'b1;
      Stall_cause = CAUSE_ICACHE;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (STALL_PC),
    .count (Stall_count)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (Redirect_valid),
    .count (Flush_count)
  );

endmodule
